div_ctrl: RTL

- Sequencer for the pipeline's multi-cycle divider.
- Accepts DIV/DIVU requests from the execute stage and runs a 32-iteration radix-2 restoring divide.
- Returns {hi=remainder, lo=quotient} for the HI/LO write path, with a one-cycle ready pulse.
- Pairs with the hazard unit's div_start/div_ready handshake: start is held high while E is stalled and drops the cycle ready is seen.

---
 rtl/div_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// div_ctrl
// Sequencer for the pipeline's multi-cycle divider. Accepts DIV/DIVU requests
// from the execute stage, runs a 32-iteration radix-2 restoring divide and
// returns {hi=remainder, lo=quotient} with a one-cycle ready pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   start      divide request, level, held until ready
//   signed_div 1 = DIV (signed), 0 = DIVU; sampled with start in IDLE
//   annul      cancel in-flight divide; dominates start
//   opdata1    dividend, sampled on accept
//   opdata2    divisor, sampled on accept
//   result     {remainder, quotient}; valid when ready=1, held until next DONE
//   ready      one-cycle done pulse
//   busy       high in ON/ZERO/DONE
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 busy
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ZERO = 2'b01;
    localparam logic [1:0] ON   = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] partRem;
    logic             quotNeg;
    logic             remNeg;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuot;

    always_comb begin
        absA     = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        absB     = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
        shifted  = {partRem, dividend[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        nextRem  = shifted[WIDTH-1:0];
        nextQuot = {dividend[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            nextRem  = trial[WIDTH-1:0];
            nextQuot = {dividend[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            counter  <= '0;
            dividend <= '0;
            divisor  <= '0;
            partRem  <= '0;
            quotNeg  <= 1'b0;
            remNeg   <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !annul) begin
                        if (opdata2 == '0) begin
                            state    <= ZERO;
                            dividend <= opdata1;
                        end else begin
                            state    <= ON;
                            dividend <= absA;
                            divisor  <= absB;
                            quotNeg  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                            remNeg   <= signed_div & opdata1[WIDTH-1];
                            counter  <= '0;
                            partRem  <= '0;
                        end
                    end
                end
                ZERO: begin
                    if (annul || !start) begin
                        state <= IDLE;
                    end else begin
                        result <= {dividend, {WIDTH{1'b1}}};
                        state  <= DONE;
                    end
                end
                ON: begin
                    if (annul || !start) begin
                        state <= IDLE;
                    end else begin
                        dividend <= nextQuot;
                        partRem  <= nextRem;
                        if (counter == CW'(WIDTH - 1)) begin
                            // Last iteration: sign fixup applied to the final
                            // step's values so result is registered on DONE entry.
                            result <= {remNeg  ? -nextRem  : nextRem,
                                       quotNeg ? -nextQuot : nextQuot};
                            state  <= DONE;
                        end else begin
                            counter <= counter + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready = (state == DONE);
    assign busy  = (state != IDLE);

endmodule
